izhikevich_state_update: RTL and testbench
==========================================

Name: izhikevich_state_update

Overview:
- Sequential integrator on the consumer side of the Izhikevich derivative datapath. It accepts dv/dw increments from the derivative units, where dw = a*(b*v - w)*step.
- Holds the neuron's v/w state registers and applies the increments with saturation.
- Performs threshold detection and the after-spike reset (v <= c, w <= w + d).
- Presents the updated state, spike flag and spike count downstream over a valid/ready handshake.

Parameters:
- N, 32, total signed fixed-point width (two's complement).
- Q, 16, fractional bits.
- V_INIT, 32'hFFBF0000, reset value of v (-65.0 in Q16.16).
- W_INIT, 32'hFFF30000, reset value of w (-13.0 in Q16.16).
- CNT_W, 16, spike counter width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  dv/dw increment valid.
- in_ready  output  1  block can accept an increment.
- dv  input  N  signed v increment (already step-scaled).
- dw  input  N  signed w increment (already step-scaled).
- v_th  input  N  signed spike threshold.
- c  input  N  signed post-spike v value.
- d  input  N  signed post-spike w increment.
- load_en  input  1  overwrite v/w with v_load/w_load.
- v_load  input  N  load value for v.
- w_load  input  N  load value for w.
- out_valid  output  1  updated state available.
- out_ready  input  1  downstream accepts state.
- v_out  output  N  current v register.
- w_out  output  N  current w register.
- spike  output  1  the presented update produced a spike.
- spike_count  output  CNT_W  saturating count of spikes since reset.

Behaviour:
- Reset (rst=1 at an edge), values next cycle:
  - v=V_INIT, w=W_INIT, state IDLE.
  - out_valid=0, spike=0, spike_count=0.
  - Any in-flight update is discarded.
- States: IDLE, INTEG, CHECK, OUT.
- in_ready = (state==IDLE) && !load_en, combinational. It is low in every other state and during load.
- IDLE:
  - If load_en: v<=v_load, w<=w_load, stay IDLE. Load takes priority over in_valid.
  - Else if in_valid: capture dv and dw, go to INTEG.
  - load_en is ignored outside IDLE.
- INTEG (1 cycle):
  - v <= sat(v+dv), w <= sat(w+dw), using the captured increments.
  - go to CHECK.
- CHECK (1 cycle): signed compare of the integrated v against v_th, sampled this cycle.
  - If v >= v_th: v <= c, w <= sat(w + d), spike <= 1, spike_count += 1. The counter saturates at all-ones and does not wrap.
  - Else: spike <= 0.
  - go to OUT.
- OUT:
  - out_valid = 1; v_out, w_out and spike are held stable until out_ready.
  - If out_ready: out_valid drops next cycle, spike clears to 0, state goes to IDLE.
- Latency: an increment accepted at edge E0 gives out_valid=1 after edge E0+2. With out_ready held high, the next acceptance is possible after E0+3, i.e. 4-cycle throughput.
- Saturation: results above 2^(N-1)-1 clamp to 32'h7FFFFFFF; results below -2^(N-1) clamp to 32'h80000000. Overflow is detected from operand and result signs.
- v_out and w_out always show the registers, including intermediate values during INTEG and CHECK. They are only guaranteed meaningful while out_valid=1.
- Backpressure: in_valid pulses while not in IDLE are ignored; nothing is queued.
- rst has priority over every other input in every state.

Test Plan:
- Reset: hold rst for 2 cycles, then release -> v_out=FFBF0000, w_out=FFF30000, out_valid=0, spike_count=0, in_ready=1.
- No spike: v_th=001E0000, dv=00010000, dw=FFFF8000, out_ready=1 -> out_valid after E0+2, v_out=FFC00000 (-64.0), w_out=FFF28000 (-13.5), spike=0.
- Spike at exact threshold:
  - Stimulus: load v=001C0000, w=FFF60000; dv=00020000, dw=0; v_th=001E0000, c=FFBF0000, d=00080000.
  - Required: v_out=FFBF0000, w_out=FFFE0000 (-2.0), spike=1, spike_count=1.
- Saturation: load w=80010000, then dw=FFFE0000, dv=0 -> w_out=80000000, spike=0. Second case: load v=7FFF0000, dv=00020000, v_th=7FFFFFFF -> v clamps to 7FFFFFFF, which meets v_th, so spike=1 and v=c.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in OUT and pulse in_valid meanwhile.
  - Required: out_valid, v_out, w_out and spike stay stable; in_ready=0; no second update occurs; the single transfer completes when out_ready=1.
- Priority and mid-op reset:
  - load_en and in_valid together in IDLE -> load applied, increment not accepted (in_ready=0).
  - rst asserted in CHECK -> next cycle shows reset values, out_valid never rises, spike_count=0.

Source files
------------

// File: rtl/izhikevich_state_update.sv
// Izhikevich neuron state integrator: applies step-scaled dv/dw with saturation,
// detects threshold crossings, applies the after-spike reset and hands the result downstream.
module izhikevich_state_update #(
  parameter int             N      = 32,
  parameter int             Q      = 16,
  parameter logic [N-1:0]   V_INIT = 32'hFFBF0000,
  parameter logic [N-1:0]   W_INIT = 32'hFFF30000,
  parameter int             CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     dv,
  input  logic [N-1:0]     dw,
  input  logic [N-1:0]     v_th,
  input  logic [N-1:0]     c,
  input  logic [N-1:0]     d,
  input  logic             load_en,
  input  logic [N-1:0]     v_load,
  input  logic [N-1:0]     w_load,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     v_out,
  output logic [N-1:0]     w_out,
  output logic             spike,
  output logic [CNT_W-1:0] spike_count
);

  typedef enum logic [1:0] {IDLE, INTEG, CHECK, OUT} state_t;

  state_t           state, state_next;
  logic [N-1:0]     v, w;
  logic [N-1:0]     dv_q, dw_q;
  logic             spike_q;
  logic [CNT_W-1:0] cnt;

  if (Q < 0 || Q >= N) begin : g_bad_q
    $error("fractional bit count must lie within the word width");
  end

  // Overflow only happens when both operands share a sign the result lacks.
  function automatic logic [N-1:0] sat_add(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] s;
    s = a + b;
    if ((a[N-1] == b[N-1]) && (s[N-1] != a[N-1]))
      return a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!load_en && in_valid) state_next = INTEG;
      INTEG:   state_next = CHECK;
      CHECK:   state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v       <= V_INIT;
      w       <= W_INIT;
      dv_q    <= '0;
      dw_q    <= '0;
      spike_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_en) begin
            v <= v_load;
            w <= w_load;
          end else if (in_valid) begin
            dv_q <= dv;
            dw_q <= dw;
          end
        end
        INTEG: begin
          v <= sat_add(v, dv_q);
          w <= sat_add(w, dw_q);
        end
        // Threshold uses the freshly integrated v; counter sticks at all-ones.
        CHECK: begin
          if ($signed(v) >= $signed(v_th)) begin
            v       <= c;
            w       <= sat_add(w, d);
            spike_q <= 1'b1;
            if (!(&cnt)) cnt <= cnt + CNT_W'(1);
          end else begin
            spike_q <= 1'b0;
          end
        end
        OUT: begin
          if (out_ready) spike_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == IDLE) && !load_en;
  assign out_valid   = (state == OUT);
  assign v_out       = v;
  assign w_out       = w;
  assign spike       = spike_q;
  assign spike_count = cnt;

endmodule

// File: tb/tb_izhikevich_state_update.sv
// Randomised and directed bench for izhikevich_state_update against a plain-arithmetic
// model of the integrate / threshold / reset behaviour.
module tb_izhikevich_state_update;

  localparam logic [31:0] V_INIT = 32'hFFBF0000;
  localparam logic [31:0] W_INIT = 32'hFFF30000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dv = '0, dw = '0, v_th = '0, c = '0, d = '0;
  logic        load_en = 1'b0;
  logic [31:0] v_load = '0, w_load = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] v_out, w_out;
  logic        spike;
  logic [15:0] spike_count;

  int passed = 0;
  int total  = 0;

  // Reference state of the neuron.
  logic [31:0] mv, mw;
  int          mcnt;
  bit          mspike;

  izhikevich_state_update dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dv(dv), .dw(dw), .v_th(v_th), .c(c), .d(d),
    .load_en(load_en), .v_load(v_load), .w_load(w_load),
    .out_valid(out_valid), .out_ready(out_ready),
    .v_out(v_out), .w_out(w_out), .spike(spike), .spike_count(spike_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sat32(input longint x);
    longint r;
    if (x > 64'sd2147483647)       r = 64'sd2147483647;
    else if (x < -64'sd2147483648) r = -64'sd2147483648;
    else                           r = x;
    return r[31:0];
  endfunction

  function automatic longint sx(input logic [31:0] a);
    longint r;
    r = $signed(a);
    return r;
  endfunction

  task automatic model_reset();
    mv = V_INIT; mw = W_INIT; mcnt = 0; mspike = 1'b0;
  endtask

  // One update: integrate, then threshold with the current v_th/c/d inputs.
  task automatic model_txn(input logic [31:0] idv, input logic [31:0] idw);
    mv = sat32(sx(mv) + sx(idv));
    mw = sat32(sx(mw) + sx(idw));
    mspike = (sx(mv) >= sx(v_th));
    if (mspike) begin
      mv = c;
      mw = sat32(sx(mw) + sx(d));
      if (mcnt < 65535) mcnt++;
    end
  endtask

  task automatic do_load(input logic [31:0] lv, input logic [31:0] lw);
    load_en = 1'b1; v_load = lv; w_load = lw;
    tick();
    load_en = 1'b0;
    mv = lv; mw = lw;
  endtask

  // Offers one increment from IDLE and waits (bounded) for out_valid.
  task automatic start_txn(input logic [31:0] idv, input logic [31:0] idw, output bit ok);
    in_valid = 1'b1; dv = idv; dw = idw;
    tick();
    in_valid = 1'b0;
    model_txn(idv, idw);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else tick();
    end
  endtask

  function automatic logic [31:0] rnd_val();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = $urandom;
      1:       r = 32'h7FF00000 + $urandom_range(0, 32'h000FFFFF);
      default: r = $urandom_range(0, 32'h00280000) - 32'h00140000;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_reset();
    total++; if (v_out !== V_INIT) $display("[TB] FAIL reset_v: got %h want %h", v_out, V_INIT); else passed++;
    total++; if (w_out !== W_INIT) $display("[TB] FAIL reset_w: got %h want %h", w_out, W_INIT); else passed++;
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (spike_count !== 16'd0) $display("[TB] FAIL reset_count: got %0d want 0", spike_count); else passed++;
    total++; if (spike !== 1'b0) $display("[TB] FAIL reset_spike: got %b want 0", spike); else passed++;
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_no_spike();
    v_th = 32'h001E0000; c = V_INIT; d = 32'h00080000; out_ready = 1'b1;
    in_valid = 1'b1; dv = 32'h00010000; dw = 32'hFFFF8000;
    tick();
    in_valid = 1'b0;
    model_txn(32'h00010000, 32'hFFFF8000);
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL lat_e1: got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b0) $display("[TB] FAIL busy_in_ready: got %b want 0", in_ready); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL lat_e2: got %b want 0", out_valid); else passed++;
    tick();
    total++; if (out_valid !== 1'b1) $display("[TB] FAIL lat_e3: got %b want 1", out_valid); else passed++;
    total++; if (v_out !== 32'hFFC00000) $display("[TB] FAIL nospike_v: got %h want %h", v_out, 32'hFFC00000); else passed++;
    total++; if (w_out !== mw) $display("[TB] FAIL nospike_w: got %h want %h", w_out, mw); else passed++;
    total++; if (spike !== 1'b0) $display("[TB] FAIL nospike_spike: got %b want 0", spike); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL nospike_drop: got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("[TB] FAIL nospike_ready: got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_spike_threshold();
    bit ok;
    do_load(32'h001C0000, 32'hFFF60000);
    v_th = 32'h001E0000; c = 32'hFFBF0000; d = 32'h00080000;
    start_txn(32'h00020000, 32'h00000000, ok);
    total++; if (!ok) $display("[TB] FAIL thr_timeout: got no out_valid want 1"); else passed++;
    total++; if (v_out !== 32'hFFBF0000) $display("[TB] FAIL thr_v: got %h want FFBF0000", v_out); else passed++;
    total++; if (w_out !== 32'hFFFE0000) $display("[TB] FAIL thr_w: got %h want FFFE0000", w_out); else passed++;
    total++; if (spike !== 1'b1) $display("[TB] FAIL thr_spike: got %b want 1", spike); else passed++;
    total++; if (spike_count !== 16'(mcnt)) $display("[TB] FAIL thr_count: got %0d want %0d", spike_count, mcnt); else passed++;
    tick();
    total++; if (spike !== 1'b0) $display("[TB] FAIL thr_spike_clear: got %b want 0", spike); else passed++;
  endtask

  task automatic test_saturation();
    bit ok;
    do_load(32'h00000000, 32'h80010000);
    v_th = 32'h001E0000;
    start_txn(32'h00000000, 32'hFFFE0000, ok);
    total++; if (!ok) $display("[TB] FAIL satlo_timeout: got no out_valid want 1"); else passed++;
    total++; if (w_out !== 32'h80000000) $display("[TB] FAIL satlo_w: got %h want 80000000", w_out); else passed++;
    total++; if (spike !== 1'b0) $display("[TB] FAIL satlo_spike: got %b want 0", spike); else passed++;
    tick();
    do_load(32'h7FFF0000, 32'h00000000);
    v_th = 32'h7FFFFFFF; c = 32'hFFBF0000; d = 32'h00000000;
    start_txn(32'h00020000, 32'h00000000, ok);
    total++; if (!ok) $display("[TB] FAIL sathi_timeout: got no out_valid want 1"); else passed++;
    total++; if (spike !== 1'b1) $display("[TB] FAIL sathi_spike: got %b want 1", spike); else passed++;
    total++; if (v_out !== 32'hFFBF0000) $display("[TB] FAIL sathi_v: got %h want FFBF0000", v_out); else passed++;
    total++; if (spike_count !== 16'(mcnt)) $display("[TB] FAIL sathi_count: got %0d want %0d", spike_count, mcnt); else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    v_th = 32'h001E0000; c = V_INIT; d = 32'h00080000;
    out_ready = 1'b0;
    start_txn(32'h00030000, 32'h00010000, ok);
    total++; if (!ok) $display("[TB] FAIL bp_timeout: got no out_valid want 1"); else passed++;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; dv = 32'h00500000; dw = 32'h00500000;
      tick();
      total++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_valid: got %b want 1", out_valid); else passed++;
      total++; if (v_out !== mv || w_out !== mw) $display("[TB] FAIL bp_hold: got %h/%h want %h/%h", v_out, w_out, mv, mw); else passed++;
      total++; if (spike !== mspike) $display("[TB] FAIL bp_spike: got %b want %b", spike, mspike); else passed++;
      total++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready: got %b want 0", in_ready); else passed++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_release: got %b want 0", out_valid); else passed++;
    tick(); tick(); tick();
    total++; if (out_valid !== 1'b0 || v_out !== mv || w_out !== mw)
      $display("[TB] FAIL bp_no_second: got %b %h/%h want 0 %h/%h", out_valid, v_out, w_out, mv, mw); else passed++;
    total++; if (spike_count !== 16'(mcnt)) $display("[TB] FAIL bp_count: got %0d want %0d", spike_count, mcnt); else passed++;
  endtask

  task automatic test_priority();
    load_en = 1'b1; in_valid = 1'b1; v_load = 32'h00050000; w_load = 32'hFFFC0000;
    dv = 32'h00010000; dw = 32'h00010000;
    #1;
    total++; if (in_ready !== 1'b0) $display("[TB] FAIL prio_in_ready: got %b want 0", in_ready); else passed++;
    tick();
    load_en = 1'b0; in_valid = 1'b0;
    mv = 32'h00050000; mw = 32'hFFFC0000;
    tick(); tick(); tick();
    total++; if (out_valid !== 1'b0) $display("[TB] FAIL prio_valid: got %b want 0", out_valid); else passed++;
    total++; if (v_out !== mv || w_out !== mw) $display("[TB] FAIL prio_load: got %h/%h want %h/%h", v_out, w_out, mv, mw); else passed++;
  endtask

  task automatic test_mid_reset();
    bit seen;
    do_load(32'h001D0000, 32'h00000000);
    v_th = 32'h001E0000;
    in_valid = 1'b1; dv = 32'h00020000; dw = 32'h0;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    total++; if (v_out !== V_INIT || w_out !== W_INIT) $display("[TB] FAIL mid_rst_vw: got %h/%h want %h/%h", v_out, w_out, V_INIT, W_INIT); else passed++;
    total++; if (spike_count !== 16'd0) $display("[TB] FAIL mid_rst_count: got %0d want 0", spike_count); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    total++; if (seen) $display("[TB] FAIL mid_rst_valid: got 1 want 0"); else passed++;
    total++; if (spike !== 1'b0) $display("[TB] FAIL mid_rst_spike: got %b want 0", spike); else passed++;
  endtask

  task automatic test_random();
    bit ok;
    int hold;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) do_load(rnd_val(), rnd_val());
      v_th = ($urandom_range(0, 3) == 0) ? rnd_val() : $urandom_range(0, 32'h00200000) - 32'h00100000;
      c = rnd_val();
      d = rnd_val();
      out_ready = 1'b0;
      start_txn(rnd_val(), rnd_val(), ok);
      total++; if (!ok) $display("[TB] FAIL rnd_timeout: got no out_valid want 1 (txn %0d)", n); else passed++;
      total++; if (v_out !== mv || w_out !== mw) $display("[TB] FAIL rnd_vw: got %h/%h want %h/%h (txn %0d)", v_out, w_out, mv, mw, n); else passed++;
      total++; if (spike !== mspike) $display("[TB] FAIL rnd_spike: got %b want %b (txn %0d)", spike, mspike, n); else passed++;
      total++; if (spike_count !== 16'(mcnt)) $display("[TB] FAIL rnd_count: got %0d want %0d (txn %0d)", spike_count, mcnt, n); else passed++;
      hold = $urandom_range(0, 3);
      for (int i = 0; i < hold; i++) tick();
      total++; if (out_valid !== 1'b1 || v_out !== mv) $display("[TB] FAIL rnd_hold: got %b %h want 1 %h (txn %0d)", out_valid, v_out, mv, n); else passed++;
      out_ready = 1'b1;
      tick();
      total++; if (out_valid !== 1'b0 || spike !== 1'b0) $display("[TB] FAIL rnd_done: got %b/%b want 0/0 (txn %0d)", out_valid, spike, n); else passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_no_spike();
    test_spike_threshold();
    test_saturation();
    test_backpressure();
    test_priority();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
